// File: rtl/bsync_trig_receiver.sv
// BSYNC receiver: learns/checks the BSYNC period, locks a phase counter to it and re-times triggers.
// Optional BSYNC_RX_TOLERANCE_EN: while locked, accept edges one cycle early or late.
module bsync_trig_receiver #(
    parameter int RATIO_WIDTH = 16,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic                   bsync_in,
    input  logic [RATIO_WIDTH-1:0] expected_ratio,
    input  logic                   trig_in,
    input  logic [RATIO_WIDTH-1:0] trig_phase,
    input  logic                   clear_error,
    output logic [1:0]             state,
    output logic                   locked,
    output logic [RATIO_WIDTH-1:0] measured_ratio,
    output logic                   bsync_event,
    output logic [RATIO_WIDTH-1:0] phase_cnt,
    output logic                   alignment_error,
    output logic                   trig_pending,
    output logic                   trig_out
);
    localparam int RW = RATIO_WIDTH;
    localparam logic [RW-1:0] CNT_MAX  = '1;
    localparam logic [RW-1:0] CNT_ONE  = RW'(1);
    localparam logic [3:0]    LOCK_CNT = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [2:0]    bsync_pipe_reg;
    logic          bsync_event_reg;
    logic [RW-1:0] period_reg;
    logic          trig_prev_reg;
    logic [3:0]    match_reg, match_next;
    logic [RW-1:0] cand_reg, cand_next;
    logic          have_cand_reg, have_cand_next;
    logic [RW-1:0] ratio_reg, ratio_next;
    logic          err_reg;
    logic          pending_reg, pending_next;
    logic          armed_reg, armed_next;
    logic          err_set;
    logic          fire;

    logic          period_sat;
    logic [RW-1:0] phase_raw;
    logic [RW-1:0] m_target;
    logic          m_hit;
    logic [3:0]    match_inc;
    logic          edge_ok;
    logic          late;
    logic          lock_fault;
    logic          trig_rise;

    assign period_sat = (period_reg == CNT_MAX);
    // The period counter already holds "cycles since edge"; only the edge cycle itself reads as 0.
    assign phase_raw  = bsync_event_reg ? '0 : period_reg;
    assign m_target   = (expected_ratio != '0) ? expected_ratio
                      : (have_cand_reg ? cand_reg : period_reg);
    assign m_hit      = !period_sat && (period_reg == m_target);
    assign match_inc  = match_reg + 4'd1;
    assign trig_rise  = trig_in && !trig_prev_reg;

`ifdef BSYNC_RX_TOLERANCE_EN
    localparam logic [RW:0] EXT_ONE = (RW+1)'(1);
    logic [RW:0] period_ext, ratio_ext;
    assign period_ext = {1'b0, period_reg};
    assign ratio_ext  = {1'b0, ratio_reg};
    assign edge_ok = !period_sat && ((period_ext == ratio_ext) ||
                                     (period_ext == ratio_ext + EXT_ONE) ||
                                     (period_ext + EXT_ONE == ratio_ext));
    assign late    = !bsync_event_reg && (period_ext == ratio_ext + EXT_ONE);
`else
    assign edge_ok = !period_sat && (period_reg == ratio_reg);
    assign late    = !bsync_event_reg && (period_reg == ratio_reg);
`endif

    assign lock_fault = (state_reg == ST_LOCKED) && (bsync_event_reg ? !edge_ok : late);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bsync_pipe_reg  <= '0;
            bsync_event_reg <= 1'b0;
            period_reg      <= '0;
            trig_prev_reg   <= 1'b0;
            state_reg       <= ST_IDLE;
            match_reg       <= '0;
            cand_reg        <= '0;
            have_cand_reg   <= 1'b0;
            ratio_reg       <= '0;
            err_reg         <= 1'b0;
            pending_reg     <= 1'b0;
            armed_reg       <= 1'b0;
        end else begin
            bsync_pipe_reg  <= {bsync_pipe_reg[1:0], bsync_in};
            bsync_event_reg <= bsync_pipe_reg[1] && !bsync_pipe_reg[2];
            if (bsync_event_reg)
                period_reg <= CNT_ONE;
            else if (!period_sat)
                period_reg <= period_reg + CNT_ONE;
            trig_prev_reg   <= trig_in;
            state_reg       <= state_next;
            match_reg       <= match_next;
            cand_reg        <= cand_next;
            have_cand_reg   <= have_cand_next;
            ratio_reg       <= ratio_next;
            pending_reg     <= pending_next;
            armed_reg       <= armed_next;
            if (err_set)
                err_reg <= 1'b1;
            else if (clear_error)
                err_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next     = state_reg;
        match_next     = match_reg;
        cand_next      = cand_reg;
        have_cand_next = have_cand_reg;
        ratio_next     = ratio_reg;
        pending_next   = pending_reg;
        armed_next     = armed_reg;
        err_set        = 1'b0;
        fire           = 1'b0;
        if (!enable) begin
            state_next     = ST_IDLE;
            match_next     = '0;
            have_cand_next = 1'b0;
            pending_next   = 1'b0;
            armed_next     = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_SEARCH;
                ST_SEARCH: begin
                    if (bsync_event_reg) begin
                        state_next     = ST_MEASURE;
                        match_next     = '0;
                        have_cand_next = 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (bsync_event_reg) begin
                        if (m_hit) begin
                            cand_next      = m_target;
                            have_cand_next = 1'b1;
                            if (match_inc == LOCK_CNT) begin
                                state_next = ST_LOCKED;
                                ratio_next = m_target;
                                match_next = '0;
                            end else begin
                                match_next = match_inc;
                            end
                        end else begin
                            match_next     = '0;
                            cand_next      = period_reg;
                            have_cand_next = !period_sat;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (lock_fault) begin
                        state_next     = ST_MEASURE;
                        match_next     = '0;
                        have_cand_next = 1'b0;
                        pending_next   = 1'b0;
                        armed_next     = 1'b0;
                        err_set        = 1'b1;
                    end else if (pending_reg) begin
                        // Unarmed: only the arming edge may fire (trig_phase 0). Armed: an edge means a full period passed.
                        fire = (phase_raw == trig_phase) && (armed_reg ? !bsync_event_reg : bsync_event_reg);
                        if (fire || (bsync_event_reg && armed_reg)) begin
                            pending_next = 1'b0;
                            armed_next   = 1'b0;
                        end else if (bsync_event_reg) begin
                            armed_next = 1'b1;
                        end
                    end else if (trig_rise) begin
                        pending_next = 1'b1;
                        armed_next   = 1'b0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign state           = state_reg;
    assign locked          = (state_reg == ST_LOCKED);
    assign measured_ratio  = ratio_reg;
    assign bsync_event     = bsync_event_reg;
    assign phase_cnt       = locked ? phase_raw : '0;
    assign alignment_error = err_reg;
    assign trig_out        = fire;
    assign trig_pending    = pending_reg && !fire;
endmodule

// File: tb/tb_bsync_trig_receiver.sv
// Scoreboard bench for bsync_trig_receiver: directed BSYNC period sequences, lock/error/trigger events checked by a monitor.
module tb_bsync_trig_receiver;
    localparam int RW = 16;
    localparam int K_LOCK = 0;
    localparam int K_ERR  = 1;
    localparam int K_TRIG = 2;
`ifdef BSYNC_RX_TOLERANCE_EN
    localparam int LATE_POS = 4;
`else
    localparam int LATE_POS = 3;
`endif

    logic          clk = 1'b0;
    logic          rstn, enable, bsync_in, trig_in, clear_error;
    logic [RW-1:0] expected_ratio, trig_phase;
    logic [1:0]    state;
    logic          locked, bsync_event, alignment_error, trig_pending, trig_out;
    logic [RW-1:0] measured_ratio, phase_cnt;

    bsync_trig_receiver #(.RATIO_WIDTH(RW), .LOCK_COUNT(4)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .bsync_in(bsync_in),
        .expected_ratio(expected_ratio), .trig_in(trig_in), .trig_phase(trig_phase),
        .clear_error(clear_error), .state(state), .locked(locked),
        .measured_ratio(measured_ratio), .bsync_event(bsync_event), .phase_cnt(phase_cnt),
        .alignment_error(alignment_error), .trig_pending(trig_pending), .trig_out(trig_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int pidx;
        int cpos;
        int val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pidx = 0;
    int   cpos = 0;
    int   trig_c = -1;
    int   clr_c = -1;
    int   en_off_c = -1;
    bit   wrap_chk = 1'b0;

    task automatic expect_ev(input int kind, input int pi, input int cp, input int v);
        exp_t e;
        e.kind = kind; e.pidx = pi; e.cpos = cp; e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic observe(input int kind, input int v);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d period=%0d pos=%0d val=%0d", kind, pidx, cpos, v);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind || e.pidx != pidx || e.cpos != cpos || e.val != v) begin
                errors++;
                $display("FAIL event actual kind=%0d period=%0d pos=%0d val=%0d expected kind=%0d period=%0d pos=%0d val=%0d",
                         kind, pidx, cpos, v, e.kind, e.pidx, e.cpos, e.val);
            end else begin
                $display("ok   event kind=%0d period=%0d pos=%0d val=%0d", kind, pidx, cpos, v);
            end
        end
    endtask

    // One BSYNC period of p cycles; the pin pulse (if any) starts at position 0.
    task automatic run_period(input int p, input bit pulse);
        pidx++;
        for (int c = 0; c < p; c++) begin
            if (wrap_chk && c == 2) chk("wrap_phase_63", int'(phase_cnt), 63);
            if (wrap_chk && c == 3) begin
                chk("wrap_event", int'(bsync_event), 1);
                chk("wrap_phase_0", int'(phase_cnt), 0);
            end
            if (wrap_chk && c == 4) chk("wrap_phase_1", int'(phase_cnt), 1);
            cpos        = c;
            bsync_in    = pulse && (c < 8);
            trig_in     = (trig_c >= 0) && (c == trig_c || c == trig_c + 1);
            clear_error = (c == clr_c);
            if (c == en_off_c) enable = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin : monitor
        logic lk_q, er_q;
        lk_q = 1'b0;
        er_q = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rstn === 1'b1) begin
                if (locked && !lk_q) observe(K_LOCK, int'(measured_ratio));
                if (alignment_error && !er_q) observe(K_ERR, int'(state));
                if (trig_out) observe(K_TRIG, int'(phase_cnt));
            end
            lk_q = locked;
            er_q = alignment_error;
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        rstn = 1'b0; enable = 1'b0; bsync_in = 1'b0; trig_in = 1'b0; clear_error = 1'b0;
        expected_ratio = '0; trig_phase = 16'd10;
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_measured", int'(measured_ratio), 0);
        chk("rst_event", int'(bsync_event), 0);
        chk("rst_phase", int'(phase_cnt), 0);
        chk("rst_error", int'(alignment_error), 0);
        chk("rst_pending", int'(trig_pending), 0);
        chk("rst_trig_out", int'(trig_out), 0);
        rstn = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        chk("search_state", int'(state), 1);

        // Learn mode, period 64: lock on the 5th edge
        expect_ev(K_LOCK, pidx + 5, 3, 64);
        repeat (5) run_period(64, 1'b1);
        chk("learn_state", int'(state), 3);
        chk("learn_ratio", int'(measured_ratio), 64);

        // Trigger captured at phase 30, fires at phase 10 of next period; second request ignored
        wrap_chk = 1'b1; trig_c = 33;
        run_period(64, 1'b1);
        wrap_chk = 1'b0; trig_c = -1;
        chk("trig_pending_set", int'(trig_pending), 1);
        expect_ev(K_TRIG, pidx + 1, 12, 10);
        trig_c = 5;
        run_period(64, 1'b1);
        trig_c = -1;
        chk("trig_pending_done", int'(trig_pending), 0);
        run_period(64, 1'b1);

        // Trigger in the event cycle: arms on the following edge
        trig_c = 3;
        run_period(64, 1'b1);
        trig_c = -1;
        chk("coinc_pending", int'(trig_pending), 1);
        expect_ev(K_TRIG, pidx + 1, 12, 10);
        run_period(64, 1'b1);
        chk("coinc_pending_done", int'(trig_pending), 0);

        // trig_phase beyond the period: no pulse, pending dropped at the next edge after arming
        trig_phase = 16'd70; trig_c = 33;
        run_period(64, 1'b1);
        trig_c = -1;
        chk("far_pending_cap", int'(trig_pending), 1);
        run_period(64, 1'b1);
        chk("far_pending_armed", int'(trig_pending), 1);
        run_period(64, 1'b1);
        chk("far_pending_clr", int'(trig_pending), 0);
        trig_phase = 16'd10;

        // Early edge at 60 with a pending trigger: error, back to MEASURE, relock after 4 periods
        trig_c = 33;
        run_period(60, 1'b1);
        trig_c = -1;
        expect_ev(K_ERR, pidx + 1, 3, 2);
        run_period(64, 1'b1);
        chk("early_error", int'(alignment_error), 1);
        chk("early_state", int'(state), 2);
        chk("early_locked", int'(locked), 0);
        chk("early_pending", int'(trig_pending), 0);
        expect_ev(K_LOCK, pidx + 4, 3, 64);
        repeat (4) run_period(64, 1'b1);
        chk("relock_state", int'(state), 3);
        chk("error_sticky", int'(alignment_error), 1);
        clr_c = 20;
        run_period(64, 1'b1);
        clr_c = -1;
        chk("error_cleared", int'(alignment_error), 0);

        // Disable while a trigger waits
        trig_c = 33;
        run_period(64, 1'b1);
        trig_c = -1;
        chk("dis_pending_cap", int'(trig_pending), 1);
        en_off_c = 8;
        run_period(64, 1'b1);
        en_off_c = -1;
        chk("dis_state", int'(state), 0);
        chk("dis_locked", int'(locked), 0);
        chk("dis_pending", int'(trig_pending), 0);
        chk("dis_ratio_held", int'(measured_ratio), 64);
        enable = 1'b1;
        expect_ev(K_LOCK, pidx + 5, 3, 64);
        repeat (5) run_period(64, 1'b1);

`ifdef BSYNC_RX_TOLERANCE_EN
        run_period(63, 1'b1);
        run_period(65, 1'b1);
        run_period(64, 1'b1);
        chk("tol_no_error", int'(alignment_error), 0);
        chk("tol_state", int'(state), 3);
`endif

        // Missing edge
        expect_ev(K_ERR, pidx + 2, LATE_POS, 2);
        run_period(64, 1'b1);
        run_period(64, 1'b0);
        run_period(64, 1'b1);
        chk("miss_state", int'(state), 2);
        chk("miss_error", int'(alignment_error), 1);

        // Check mode: 100 required, 64 supplied never locks; trigger ignored while unlocked
        expected_ratio = 16'd100;
        trig_c = 33;
        run_period(64, 1'b1);
        trig_c = -1;
        chk("unlocked_trig_ignored", int'(trig_pending), 0);
        repeat (5) run_period(64, 1'b1);
        chk("check_state", int'(state), 2);
        chk("check_locked", int'(locked), 0);
        expect_ev(K_LOCK, pidx + 5, 3, 100);
        repeat (5) run_period(100, 1'b1);
        chk("check_ratio", int'(measured_ratio), 100);
        chk("check_locked_100", int'(locked), 1);

        repeat (5) @(negedge clk);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event kind=%0d period=%0d pos=%0d val=%0d", e.kind, e.pidx, e.cpos, e.val);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
